block_draw_engine: RTL and testbench
====================================

// Module: block_draw_engine
//
// PURPOSE
// Pixel-plot engine between the gameplay datapath and the VGA adapter (160x120, 3-bit colour).
// Per request: optionally erases a BLK_W x BLK_H block at an old position with background colour,
// then draws the same-size block at a new position in a given colour, one pixel per clock.
// Converts (x,y) block positions from the datapath into the adapter's x/y/colour/plot stream.
//
// PARAMETERS
// BLK_W      20      block width in pixels (1..64)
// BLK_H      4       block height in pixels (1..16)
// SCREEN_W   160     visible width; pixels with x >= SCREEN_W are clipped
// SCREEN_H   120     visible height; pixels with y >= SCREEN_H are clipped
// BG_COLOUR  3'b000  colour used in the erase pass
//
// PORTS
// clk         in   1  system clock, 50 MHz
// resetn      in   1  synchronous, active-low reset
// start       in   1  request; sampled only in IDLE
// erase_en    in   1  1 = run erase pass before draw pass
// erase_x     in   8  top-left x of block to erase
// erase_y     in   7  top-left y of block to erase
// draw_x      in   8  top-left x of block to draw
// draw_y      in   7  top-left y of block to draw
// colour      in   3  draw colour
// vga_x       out  8  pixel x to adapter
// vga_y       out  7  pixel y to adapter
// vga_colour  out  3  pixel colour to adapter
// vga_plot    out  1  write strobe to adapter
// busy        out  1  high in ERASE, DRAW, DONE
// done        out  1  one-cycle pulse in DONE
//
// BEHAVIOUR
// - Reset: state IDLE, counters 0, latched inputs 0; all outputs 0. Reset wins over any state,
//   aborts an operation immediately with no done pulse.
// - States: IDLE, ERASE, DRAW, DONE.
//   IDLE:  start=1 -> latch erase_en/erase_x/erase_y/draw_x/draw_y/colour; next ERASE if erase_en else DRAW.
//   ERASE: BLK_W*BLK_H cycles; last pixel -> DRAW.  DRAW: BLK_W*BLK_H cycles; last pixel -> DONE.
//   DONE:  1 cycle, done=1 -> IDLE. start held high restarts after exactly one IDLE cycle.
// - Inputs change freely after the start edge; only latched copies are used. start ignored when busy.
// - Raster order per pass: px inner 0..BLK_W-1, py outer 0..BLK_H-1; counters cleared on pass entry.
// - Pixel address: 9-bit sum base_x+px, 8-bit sum base_y+py (no wrap). If sum_x >= SCREEN_W or
//   sum_y >= SCREEN_H: vga_plot=0, vga_x=0, vga_y=0 for that cycle; cycle still consumed
//   (latency independent of position). Else vga_x/vga_y = sum (truncated), vga_plot=1.
// - vga_colour = BG_COLOUR in ERASE, latched colour in DRAW, 0 otherwise. vga_plot=0 outside ERASE/DRAW.
// - Outputs derived from state and counter registers only (no input-to-output comb path).
// - Timing (start sampled at edge 0): erase_en=0 -> DRAW cycles 1..N, DONE cycle N+1, N=BLK_W*BLK_H;
//   erase_en=1 -> ERASE 1..N, DRAW N+1..2N, DONE 2N+1.
// - Overlapping erase/draw blocks legal: draw pass always last, so new block wins.
//
// TESTING (defaults)
// 1 resetn=0 two cycles, start=1 -> all outputs 0, busy=0, no plot; stays IDLE while resetn=0.
// 2 start, erase_en=0, draw (10,20), colour 3'b100 -> 80 plots cycles 1..80, first (10,20), last (29,23),
//   raster order, colour 100; done=1 cycle 81 only; busy cycles 1..81.
// 3 start, erase_en=1, erase (0,0), draw (0,4), colour 3'b010 -> plots 1..80 colour 000 rows 0..3,
//   81..160 colour 010 rows 4..7; done cycle 161.
// 4 draw (150,118), erase_en=0 -> 80 busy cycles, only 20 plots: x 150..159, y 118..119; clipped cycles plot=0.
// 5 start pulsed during DRAW with other inputs changed -> ignored, original block completes;
//   start held high -> second op begins after one IDLE cycle.
// 6 resetn=0 at DRAW cycle 30 -> next cycle IDLE, plot=0, busy=0, no done; new start runs full from px=py=0.

Source files
------------

// File: rtl/block_draw_engine.sv
// Block plot engine: optional erase of a BLK_W x BLK_H block at an old position,
// then a draw at a new position, streamed one pixel per clock to the VGA adapter.
module block_draw_engine #(
    parameter int unsigned BLK_W     = 20,
    parameter int unsigned BLK_H     = 4,
    parameter int unsigned SCREEN_W  = 160,
    parameter int unsigned SCREEN_H  = 120,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       erase_en,
    input  logic [7:0] erase_x,
    input  logic [6:0] erase_y,
    input  logic [7:0] draw_x,
    input  logic [6:0] draw_y,
    input  logic [2:0] colour,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ERASE,
        S_DRAW,
        S_DONE
    } state_t;

    localparam logic [5:0] PX_MAX = 6'(BLK_W - 1);
    localparam logic [3:0] PY_MAX = 4'(BLK_H - 1);
    localparam logic [8:0] SW_LIM = 9'(SCREEN_W);
    localparam logic [7:0] SH_LIM = 8'(SCREEN_H);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_px;
    logic [3:0] r_py;
    logic       r_erase_en;
    logic [7:0] r_erase_x;
    logic [6:0] r_erase_y;
    logic [7:0] r_draw_x;
    logic [6:0] r_draw_y;
    logic [2:0] r_colour;

    logic       w_last_px;
    logic       w_pass_end;
    logic       w_active;
    logic [7:0] w_base_x;
    logic [6:0] w_base_y;
    logic [8:0] w_sum_x;
    logic [7:0] w_sum_y;
    logic       w_visible;

    assign w_last_px  = (r_px == PX_MAX);
    assign w_pass_end = w_last_px && (r_py == PY_MAX);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_px       <= '0;
            r_py       <= '0;
            r_erase_en <= 1'b0;
            r_erase_x  <= '0;
            r_erase_y  <= '0;
            r_draw_x   <= '0;
            r_draw_y   <= '0;
            r_colour   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_px <= '0;
                    r_py <= '0;
                    if (start) begin
                        r_erase_en <= erase_en;
                        r_erase_x  <= erase_x;
                        r_erase_y  <= erase_y;
                        r_draw_x   <= draw_x;
                        r_draw_y   <= draw_y;
                        r_colour   <= colour;
                    end
                end
                S_ERASE, S_DRAW: begin
                    // Counters wrap to zero on the last pixel, so the next pass starts clean
                    if (w_last_px) begin
                        r_px <= '0;
                        r_py <= (r_py == PY_MAX) ? '0 : r_py + 4'd1;
                    end else begin
                        r_px <= r_px + 6'd1;
                    end
                end
                default: begin
                    r_px <= '0;
                    r_py <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = erase_en ? S_ERASE : S_DRAW;
            S_ERASE: if (w_pass_end) w_next = S_DRAW;
            S_DRAW:  if (w_pass_end) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        busy       = (r_state != S_IDLE);
        done       = (r_state == S_DONE);
        w_active   = (r_state == S_ERASE) || (r_state == S_DRAW);
        w_base_x   = (r_state == S_ERASE) ? r_erase_x : r_draw_x;
        w_base_y   = (r_state == S_ERASE) ? r_erase_y : r_draw_y;
        w_sum_x    = {1'b0, w_base_x} + {3'b000, r_px};
        w_sum_y    = {1'b0, w_base_y} + {4'b0000, r_py};
        w_visible  = (w_sum_x < SW_LIM) && (w_sum_y < SH_LIM);
        if (r_state == S_ERASE) vga_colour = BG_COLOUR;
        if (r_state == S_DRAW)  vga_colour = r_colour;
        // Off-screen pixels still take their cycle so pass length never depends on position
        if (w_active && w_visible) begin
            vga_plot = 1'b1;
            vga_x    = w_sum_x[7:0];
            vga_y    = w_sum_y[6:0];
        end
    end

endmodule

// File: tb/tb_block_draw_engine.sv
// Scoreboard bench for block_draw_engine: stimulus pushes expected pixel/done events,
// a monitor pops and compares them, cycle-stamped, whenever the DUT presents output.
module tb_block_draw_engine;

    localparam int BW = 20;
    localparam int BH = 4;
    localparam int N  = BW * BH;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       erase_en;
    logic [7:0] erase_x;
    logic [6:0] erase_y;
    logic [7:0] draw_x;
    logic [6:0] draw_y;
    logic [2:0] colour;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    block_draw_engine #(
        .BLK_W    (BW),
        .BLK_H    (BH),
        .SCREEN_W (160),
        .SCREEN_H (120),
        .BG_COLOUR(3'b000)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .erase_en  (erase_en),
        .erase_x   (erase_x),
        .erase_y   (erase_y),
        .draw_x    (draw_x),
        .draw_y    (draw_y),
        .colour    (colour),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .vga_plot  (vga_plot),
        .busy      (busy),
        .done      (done)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit is_done;
        int x;
        int y;
        int col;
        int cyc;
    } exp_t;

    exp_t q[$];
    bit   busy_map[int];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
        end
    endtask

    // Reference: a pass covers BW x BH pixels in raster order, one per cycle from c_start.
    function automatic void model_pass(input int bx, input int by, input int col, input int c_start);
        for (int py = 0; py < BH; py++)
            for (int px = 0; px < BW; px++) begin
                exp_t e;
                e.is_done = 1'b0;
                e.x   = bx + px;
                e.y   = by + py;
                e.col = col;
                e.cyc = c_start + py * BW + px;
                if (e.x < 160 && e.y < 120) q.push_back(e);
            end
    endfunction

    function automatic int op_len(input bit ee);
        return ee ? 2 * N : N;
    endfunction

    // Drive a request (start left high) and record what it must produce if sampled at c0.
    task automatic issue(input bit ee, input int ex, input int ey, input int dx, input int dy,
                         input int col, input int c0);
        exp_t d;
        erase_en = ee;
        erase_x  = 8'(ex);
        erase_y  = 7'(ey);
        draw_x   = 8'(dx);
        draw_y   = 7'(dy);
        colour   = 3'(col);
        start    = 1'b1;
        if (ee) model_pass(ex, ey, 0, c0);
        model_pass(dx, dy, col, c0 + (ee ? N : 0));
        d.is_done = 1'b1;
        d.x = 0; d.y = 0; d.col = 0;
        d.cyc = c0 + op_len(ee);
        q.push_back(d);
        for (int c = c0; c <= c0 + op_len(ee); c++) busy_map[c] = 1'b1;
    endtask

    task automatic run_op(input bit ee, input int ex, input int ey, input int dx, input int dy,
                          input int col);
        int c0;
        c0 = cyc + 1;
        issue(ee, ex, ey, dx, dy, col, c0);
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + op_len(ee) + 1) @(negedge clk);
    endtask

    task automatic flush_after(input int now);
        exp_t keep[$];
        foreach (q[i]) if (q[i].cyc <= now) keep.push_back(q[i]);
        q = keep;
        foreach (busy_map[k]) if (k > now) busy_map.delete(k);
    endtask

    always @(posedge clk) begin
        bit exp_busy;
        exp_t e;
        #1;
        cyc++;
        exp_busy = busy_map.exists(cyc);
        check("busy", int'(busy), int'(exp_busy));
        if (vga_plot || done) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output cyc=%0d actual plot=%0b done=%0b x=%0d y=%0d required no output",
                         cyc, vga_plot, done, vga_x, vga_y);
            end else begin
                e = q.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("done", int'(done), int'(e.is_done));
                check("plot", int'(vga_plot), int'(!e.is_done));
                if (!e.is_done) begin
                    check("vga_x", int'(vga_x), e.x);
                    check("vga_y", int'(vga_y), e.y);
                    check("vga_colour", int'(vga_colour), e.col);
                end
            end
        end else begin
            check("noplot_x", int'(vga_x), 0);
            check("noplot_y", int'(vga_y), 0);
        end
        if (!exp_busy) check("idle_colour", int'(vga_colour), 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int cb;
        resetn   = 1'b0;
        start    = 1'b1;
        erase_en = 1'b1;
        erase_x  = 8'd5;
        erase_y  = 7'd5;
        draw_x   = 8'd7;
        draw_y   = 7'd7;
        colour   = 3'b111;
        repeat (2) @(negedge clk);
        start  = 1'b0;
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        run_op(1'b0, 0, 0, 10, 20, 3'b100);
        run_op(1'b1, 0, 0, 0, 4, 3'b010);
        run_op(1'b0, 0, 0, 150, 118, 3'b001);

        // Start pulse during DRAW is ignored; held start relaunches after one IDLE cycle
        c0 = cyc + 1;
        issue(1'b0, 0, 0, 40, 50, 3'b011, c0);
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 20) @(negedge clk);
        start    = 1'b1;
        erase_en = 1'b1;
        draw_x   = 8'd3;
        draw_y   = 7'd3;
        colour   = 3'b111;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 50) @(negedge clk);
        cb = c0 + N + 2;
        issue(1'b1, 40, 50, 60, 70, 3'b101, cb);
        while (cyc < cb) @(negedge clk);
        start = 1'b0;
        while (cyc < cb + 2 * N + 1) @(negedge clk);

        // Reset at DRAW cycle 30 aborts with no done pulse
        c0 = cyc + 1;
        issue(1'b0, 0, 0, 30, 40, 3'b110, c0);
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 29) @(negedge clk);
        resetn = 1'b0;
        flush_after(cyc);
        @(negedge clk);
        resetn = 1'b1;
        run_op(1'b0, 0, 0, 30, 40, 3'b110);

        for (int i = 0; i < 20; i++) begin
            run_op(1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 170)), int'($urandom_range(0, 127)),
                   int'($urandom_range(0, 170)), int'($urandom_range(0, 127)),
                   int'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
